// File: rtl/hit_judge_if.sv
// Judge-side bundle: note/fret/strum inputs and the judgement, LED and streak outputs.
// The judge uses the slave modport; the stimulus side uses the master modport.
interface hit_judge_if #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned STREAK_W = 8
);
  logic [LANES-1:0]    note_arrive;
  logic [LANES-1:0]    fret;
  logic                strum;
  logic                note_hit;
  logic                note_miss;
  logic [LANES-1:0]    lane_armed;
  logic [STREAK_W-1:0] streak;

  modport master (
    output note_arrive, fret, strum,
    input  note_hit, note_miss, lane_armed, streak
  );

  modport slave (
    input  note_arrive, fret, strum,
    output note_hit, note_miss, lane_armed, streak
  );
endinterface

// File: rtl/hit_judge.sv
// Per-lane hit-window judge producing note_hit/note_miss pulses, armed LEDs and a streak.
// Optional overstrum miss is enabled by defining HIT_JUDGE_OVERSTRUM_EN.
module hit_judge #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned WINDOW   = 2500000,
  parameter int unsigned CNT_W    = 22,
  parameter int unsigned STREAK_W = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  hit_judge_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } lane_state_t;

  localparam logic [CNT_W-1:0]    RELOAD     = CNT_W'(WINDOW - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = '1;

  logic                strum_d;
  logic                note_hit_q;
  logic                note_miss_q;
  logic [LANES-1:0]    lane_armed_q;
  logic [STREAK_W-1:0] streak_q;

  logic             strum_rise_c;
  logic             any_armed_c;
  logic             resolve_c;
  logic             chord_ok_c;
  logic             hit_evt_c;
  logic             miss_evt_c;
  logic             overstrum_c;
  logic [LANES-1:0] armed_vec_c;
  logic [LANES-1:0] armed_next_c;
  logic [LANES-1:0] lane_miss_c;

  // Strum edge and chord resolution shared by all lanes
  assign strum_rise_c = bus.strum & ~strum_d;
  assign any_armed_c  = |armed_vec_c;
  assign resolve_c    = strum_rise_c & any_armed_c;
  assign chord_ok_c   = &(bus.fret | ~armed_vec_c);
  assign hit_evt_c    = resolve_c & chord_ok_c;

`ifdef HIT_JUDGE_OVERSTRUM_EN
  assign overstrum_c = strum_rise_c & ~any_armed_c;
`else
  assign overstrum_c = 1'b0;
`endif

  assign miss_evt_c = (resolve_c & ~chord_ok_c) | (|lane_miss_c) | overstrum_c;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_state_t      state_q;
    lane_state_t      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             miss_c;

    always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // A strum resolves before a same-cycle arrival re-arms the lane
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      miss_c  = 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.note_arrive[g]) begin
            state_d = ARMED;
            cnt_d   = RELOAD;
          end
        end
        ARMED: begin
          if (resolve_c) begin
            state_d = IDLE;
            if (bus.note_arrive[g]) begin
              state_d = ARMED;
              cnt_d   = RELOAD;
            end
          end else if (bus.note_arrive[g]) begin
            miss_c = 1'b1;
            cnt_d  = RELOAD;
          end else if (cnt_q == '0) begin
            miss_c  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign armed_vec_c[g]  = (state_q == ARMED);
    assign armed_next_c[g] = (state_d == ARMED);
    assign lane_miss_c[g]  = miss_c;
  end

  // Registered judgement pulses, LEDs and saturating streak
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      strum_d      <= 1'b0;
      note_hit_q   <= 1'b0;
      note_miss_q  <= 1'b0;
      lane_armed_q <= '0;
      streak_q     <= '0;
    end else begin
      strum_d      <= bus.strum;
      note_hit_q   <= hit_evt_c;
      note_miss_q  <= miss_evt_c;
      lane_armed_q <= armed_next_c;
      if (miss_evt_c) begin
        streak_q <= '0;
      end else if (hit_evt_c && (streak_q != STREAK_MAX)) begin
        streak_q <= streak_q + STREAK_W'(1);
      end
    end
  end

  assign bus.note_hit   = note_hit_q;
  assign bus.note_miss  = note_miss_q;
  assign bus.lane_armed = lane_armed_q;
  assign bus.streak     = streak_q;

endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge with WINDOW=4, LANES=4, STREAK_W=8.
// Reference model tracks each armed lane by the absolute edge at which it expires.
module tb_hit_judge;

  localparam int LANES  = 4;
  localparam int WINDOW = 4;

  typedef struct packed {
    logic       hit;
    logic       miss;
    logic [3:0] armed;
    logic [7:0] streak;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hit_judge_if #(.LANES(LANES), .STREAK_W(8)) bus ();

  hit_judge #(
    .LANES   (LANES),
    .WINDOW  (WINDOW),
    .CNT_W   (3),
    .STREAK_W(8)
  ) dut (
    .clk    (clk),
    .reset_n(rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  logic [3:0]  m_armed = '0;
  int          m_end[LANES];
  logic        m_sd = 1'b0;
  int unsigned m_streak = 0;
  int          cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Drive one cycle, predict the registered result, then compare after the edge
  task automatic step(input logic [3:0] a, input logic [3:0] f, input logic s);
    exp_t e;
    logic rise, any, res, ok, hit, miss;
    @(negedge clk);
    bus.note_arrive = a;
    bus.fret        = f;
    bus.strum       = s;
    cyc++;
    rise = s & ~m_sd;
    any  = |m_armed;
    res  = rise & any;
    ok   = ((f & m_armed) == m_armed);
    hit  = res & ok;
    miss = res & ~ok;
`ifdef HIT_JUDGE_OVERSTRUM_EN
    if (rise && !any) miss = 1'b1;
`endif
    for (int i = 0; i < LANES; i++) begin
      if (m_armed[i] && !res) begin
        if (a[i]) begin
          miss     = 1'b1;
          m_end[i] = cyc + WINDOW;
        end else if (cyc == m_end[i]) begin
          miss       = 1'b1;
          m_armed[i] = 1'b0;
        end
      end else begin
        m_armed[i] = a[i];
        if (a[i]) m_end[i] = cyc + WINDOW;
      end
    end
    if (miss) m_streak = 0;
    else if (hit && m_streak < 255) m_streak++;
    m_sd     = s;
    e.hit    = hit;
    e.miss   = miss;
    e.armed  = m_armed;
    e.streak = 8'(m_streak);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("note_hit",   32'(bus.note_hit),   32'(e.hit));
    check("note_miss",  32'(bus.note_miss),  32'(e.miss));
    check("lane_armed", 32'(bus.lane_armed), 32'(e.armed));
    check("streak",     32'(bus.streak),     32'(e.streak));
  endtask

  task automatic do_reset();
    bus.note_arrive = '0;
    bus.fret        = '0;
    bus.strum       = 1'b0;
    rst             = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    m_armed  = '0;
    m_sd     = 1'b0;
    m_streak = 0;
    sb.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hit"},    32'(bus.note_hit),   32'd0);
    check({tag, "_miss"},   32'(bus.note_miss),  32'd0);
    check({tag, "_armed"},  32'(bus.lane_armed), 32'd0);
    check({tag, "_streak"}, 32'(bus.streak),     32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset();
    #1;
    check_zero("reset");

    // Single hit on lane 0
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0000, 4'b0001, 1'b0);
    step(4'b0000, 4'b0001, 1'b1);
    step(4'b0000, 4'b0001, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Expiry on lane 1, then a last-cycle hit
    step(4'b0010, 4'b0000, 1'b0);
    repeat (5) step(4'b0000, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 1'b0);
    repeat (3) step(4'b0000, 4'b0010, 1'b0);
    step(4'b0000, 4'b0010, 1'b1);
    repeat (2) step(4'b0000, 4'b0000, 1'b0);

    // Chord on lanes 0 and 2: wrong frets, then correct with an extra fret
    step(4'b0101, 4'b0000, 1'b0);
    step(4'b0000, 4'b0001, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0101, 4'b0000, 1'b0);
    step(4'b0000, 4'b0111, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);

    // Three hits in a row, then an expiry clears the streak
    for (int n = 0; n < 3; n++) begin
      step(4'b1000, 4'b1000, 1'b0);
      step(4'b0000, 4'b1000, 1'b1);
    end
    step(4'b0100, 4'b0000, 1'b0);
    repeat (5) step(4'b0000, 4'b0000, 1'b0);

    // Re-arrival on an armed lane counts as a miss and reloads the window
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    repeat (6) step(4'b0000, 4'b0000, 1'b0);

    // Strum held across two windows judges only the first
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0000, 4'b0001, 1'b1);
    step(4'b0001, 4'b0001, 1'b1);
    repeat (5) step(4'b0000, 4'b0001, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);

    // Strum with nothing armed
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0000, 4'b0001, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b1);
    repeat (2) step(4'b0000, 4'b0000, 1'b0);

    // Saturate the streak
    for (int n = 0; n < 260; n++) begin
      step(4'b0011, 4'b0011, 1'b0);
      step(4'b0000, 4'b1011, 1'b1);
    end

    // Randomised traffic
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
           4'($urandom), 1'($urandom_range(0, 1)));
    end
    step(4'b0000, 4'b0000, 1'b0);
    for (int n = 0; n < 40; n++) begin
      step(4'b0011, 4'b0011, 1'b0);
      step(4'b0000, 4'b0011, 1'b1);
    end

    // Asynchronous reset in the middle of a window
    step(4'b0110, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    do_reset();
    repeat (6) step(4'b0000, 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Timing judge that produces the note_hit / note_miss pulse pair consumed by the scoring block.
- Per fret lane, opens a hit window when the note highway reports a note reaching the strike line.
- Resolves each window against strum and fret inputs, and emits exactly one judgement pulse per resolution.
- Also drives lane-armed LEDs and a running note streak.

Parameters:
- LANES, 4: number of fret lanes.
- WINDOW, 2500000: hit-window length in clk cycles (50 ms at 50 MHz); must be >= 2.
- CNT_W, 22: window counter width; must satisfy 2^CNT_W > WINDOW.
- STREAK_W, 8: streak counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, active-high (1 = in reset) despite the name.
- note_arrive  in  LANES  one-cycle pulse per lane when a note reaches the strike line.
- fret  in  LANES  fret button levels, 1 = held; already synchronised.
- strum  in  1  strum bar level, 1 = pressed; already synchronised.
- note_hit  out  1  one-cycle pulse: note(s) played correctly.
- note_miss  out  1  one-cycle pulse: note(s) missed or played wrong.
- lane_armed  out  LANES  1 while the lane's window is open.
- streak  out  STREAK_W  consecutive-hit count, saturating.

Behaviour:
- Reset (async, reset_n=1): all lane counters idle; lane_armed=0, note_hit=0, note_miss=0, streak=0, strum_d=0. Takes effect immediately. No pulse is generated for windows killed by reset.
- Strum edge: strum_rise = strum & ~strum_d, where strum_d is a 1-flop delayed copy. Holding the strum bar produces only one edge.
- Per-lane FSM has two states, IDLE and ARMED, with counter cnt[CNT_W].
- IDLE + note_arrive at edge k: go to ARMED, cnt = WINDOW-1. The lane is armed during cycles k+1 .. k+WINDOW.
- ARMED: cnt decrements each cycle. Expiry occurs when cnt==0 and there is no strum_rise in that cycle; the lane returns to IDLE and a miss is raised.
- Strum resolution, when strum_rise is sampled at edge j and any lane is armed:
  - Hit if fret has a 1 in every armed lane (extra held frets allowed).
  - Otherwise miss.
  - All armed lanes go to IDLE together. One pulse total regardless of chord size.
- Same-cycle note_arrive on a lane:
  - If the lane is being resolved by strum, it is re-armed fresh after resolution.
  - If the lane is ARMED and not strummed, the old note counts as a miss and the lane reloads cnt = WINDOW-1.
- Outputs are registered; judgement for events sampled at edge j appears in cycle j+1 and lasts 1 cycle.
- Priority within one cycle: a strum hit takes precedence, with misses from the same cycle merged in.
  - hit_evt and no miss_evt: note_hit=1.
  - miss_evt (any source): note_miss=1, and note_hit=1 only if strum also hit.
  - The scoring block already treats miss with priority for the multiplier, so both may assert together. Several expiries in one cycle produce a single note_miss pulse.
- streak:
  - +1 on note_hit without note_miss.
  - Cleared on any note_miss.
  - Saturates at 2^STREAK_W-1 and does not wrap.
  - Updates in the same cycle the pulse is registered.
- Strum with no lane armed: see Optional Feature.
- lane_armed[i] = (state_i == ARMED), registered.

Optional Feature:
- Macro: HIT_JUDGE_OVERSTRUM_EN.
- Defined: a strum_rise with no lane armed is an overstrum and produces note_miss=1 in the next cycle; streak clears.
- Undefined: a strum_rise with no lane armed is ignored (no pulse, streak unchanged).

Test Plan (WINDOW=4, LANES=4):
- Single hit: note_arrive=0001 at edge k; fret=0001; strum rises sampled at k+2 -> note_hit=1 in cycle k+3 only, note_miss=0, lane_armed=0000 from k+3, streak=1.
- Expiry: note_arrive=0010 at k, no strum -> lane_armed[1]=1 during k+1..k+4; note_miss=1 in cycle k+5; streak=0. Repeat with strum sampled at k+4 and fret=0010 -> note_hit in k+5 (last-cycle hit).
- Chord: lanes 0 and 2 armed. fret=0001 plus strum -> single note_miss, lane_armed=0000. fret=0111 plus strum -> single note_hit.
- Streak: three consecutive hits -> streak 1,2,3; then one expiry -> streak 0. Force 255 hits with STREAK_W=8 -> streak stays 255 on the 256th.
- Re-arrive and held strum: lane 0 armed and note_arrive=0001 again at cnt=2 -> note_miss next cycle, lane stays armed with fresh window. Strum held high across two windows -> only first window judged by strum.
- Reset and overstrum:
  - reset_n=1 mid-window -> outputs 0 asynchronously; after release no pulse.
  - Strum with nothing armed -> note_miss=1 with HIT_JUDGE_OVERSTRUM_EN, no pulse without it.
